pp_accum_shift_reg: RTL and testbench

Parametrised partial-product accumulate-and-shift register for the sequential radix-2^DIGIT Booth multiplier datapath. It accepts one signed partial product per step over a valid/ready handshake, least-significant digit first. Each step it adds the partial product into the running high word, then arithmetically shifts DIGIT retired bits into the low word. After WIDTH/DIGIT steps it presents the full 2*WIDTH-bit signed product on an output handshake.

---
 rtl/pp_accum_shift_reg.sv | 130 +++++++++++++
 tb/tb_pp_accum_shift_reg.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_accum_shift_reg.sv
// pp_accum_shift_reg: accumulate-and-shift register for a sequential
// radix-2^DIGIT Booth multiplier. One signed partial product per step
// arrives LS digit first; after WIDTH/DIGIT steps the signed product is
// offered on an output handshake.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               begin a new multiplication
//   pp_valid/pp_ready   partial-product handshake, pp_data (WIDTH+DIGIT)
//   out_valid/out_ready product handshake, product (2*WIDTH)
//   busy                operation in progress or product pending
//   abort               only when PP_ACC_ABORT_EN is defined
module pp_accum_shift_reg #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   pp_valid,
    output logic                   pp_ready,
    input  logic [WIDTH+DIGIT-1:0] pp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     product,
`ifdef PP_ACC_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   busy
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int PW    = WIDTH + DIGIT;
    localparam int SW    = PW + 1;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic signed [PW-1:0] p_q, p_d;
    logic [WIDTH-1:0]     l_q, l_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [SW-1:0] sum;
    logic                 kill;
    logic                 clr;
    logic                 last;

`ifdef PP_ACC_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    // One guard bit keeps the add exact before the arithmetic shift.
    assign sum  = $signed({p_q[PW-1], p_q}) + $signed({pp_data[PW-1], pp_data});
    assign last = (cnt_q == CW'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            l_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        l_d     = l_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        if (kill) begin
            state_d = IDLE;
            clr     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = ACCUM;
                        clr     = 1'b1;
                    end
                end
                ACCUM: begin
                    if (pp_valid) begin
                        p_d   = PW'(sum >>> DIGIT);
                        // Retired digit enters the low word from the top.
                        l_d   = (l_q >> DIGIT)
                              | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));
                        cnt_d = cnt_q + CW'(1);
                        if (last) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = start ? ACCUM : IDLE;
                        clr     = start;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if (clr) begin
            p_d   = '0;
            l_d   = '0;
            cnt_d = '0;
        end
    end

    always_comb begin
        pp_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    assign product = {p_q[WIDTH-1:0], l_q};

endmodule

// File: tb/tb_pp_accum_shift_reg.sv
// tb_pp_accum_shift_reg: self-checking bench for pp_accum_shift_reg.
// Directed Booth cases plus randomized handshakes against a sum model.
module tb_pp_accum_shift_reg;

    localparam int W     = 16;
    localparam int D     = 4;
    localparam int STEPS = W / D;
    localparam int PW    = W + D;
    localparam int PPMAX = (1 << (D - 1)) * (1 << (W - 1));

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          pp_valid;
    logic          pp_ready;
    logic [PW-1:0] pp_data;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] product;
    logic          busy;
`ifdef PP_ACC_ABORT_EN
    logic          abort;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t0    = 0;
    int lat;

    int             m_mode = 0;
    int             m_q[$];
    logic [2*W-1:0] m_prod = '0;

    pp_accum_shift_reg #(.WIDTH(W), .DIGIT(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pp_valid  (pp_valid),
        .pp_ready  (pp_ready),
        .pp_data   (pp_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
`ifdef PP_ACC_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chkp(input string name, input logic [2*W-1:0] act,
                        input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] enc(input int v);
        return PW'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic feed(input int d0, input int d1, input int d2, input int d3,
                        input int g1, input int g2);
        int d[4];
        int g[4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        g[0] = 0;  g[1] = g1; g[2] = g2; g[3] = 0;
        for (int k = 0; k < 4; k++) begin
            repeat (g[k]) begin
                pp_valid = 1'b0;
                pp_data  = enc(int'($urandom_range(0, 255)));
                step();
            end
            pp_valid = 1'b1;
            pp_data  = enc(d[k]);
            step();
        end
        pp_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chkb("wait_out_valid", out_valid, 1'b1);
        l = cyc - t0 + 1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chkb("release_idle", busy, 1'b0);
    endtask

    // Reference: product is the sum of partial products weighted by
    // 2^(DIGIT*k); handshake state tracked as idle / accumulating / done.
    initial begin : model
        logic   ab;
        longint acc;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_mode = 0;
                m_q.delete();
                chkb("rst_pp_ready", pp_ready, 1'b0);
                chkb("rst_out_valid", out_valid, 1'b0);
                chkb("rst_busy", busy, 1'b0);
                chkp("rst_product", product, '0);
            end else begin
                chkb("pp_ready", pp_ready, m_mode == 1);
                chkb("out_valid", out_valid, m_mode == 2);
                chkb("busy", busy, m_mode != 0);
                if (m_mode == 2) chkp("product", product, m_prod);
                ab = 1'b0;
`ifdef PP_ACC_ABORT_EN
                ab = abort;
`endif
                if (ab) begin
                    m_mode = 0;
                    m_q.delete();
                end else if (m_mode == 0) begin
                    if (start) begin
                        m_mode = 1;
                        m_q.delete();
                    end
                end else if (m_mode == 1) begin
                    if (pp_valid) begin
                        m_q.push_back(int'($signed(pp_data)));
                        if (m_q.size() == STEPS) begin
                            acc = 0;
                            for (int k = 0; k < STEPS; k++)
                                acc += longint'(m_q[k]) * (longint'(1) << (D * k));
                            m_prod = acc[2*W-1:0];
                            m_mode = 2;
                        end
                    end
                end else begin
                    if (out_ready) begin
                        m_mode = start ? 1 : 0;
                        m_q.delete();
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        pp_valid  = 1'b0;
        out_ready = 1'b0;
        pp_data   = '0;
`ifdef PP_ACC_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // 15 x 1
        kick();
        feed(15, 0, 0, 0, 0, 0);
        wait_done(lat);
        chki("t1_latency", lat, 5);
        chkp("t1_product", product, 32'h0000000F);
        chkp("t1_model_pin", m_prod, 32'h0000000F);
        release_out();

        // 2 x 9, Booth digits -7,+1
        kick();
        feed(-14, 2, 0, 0, 0, 0);
        wait_done(lat);
        chki("t3_latency", lat, 5);
        chkp("t3_product", product, 32'h00000012);
        release_out();

        // same with 1- and 3-cycle pp_valid gaps
        kick();
        feed(-14, 2, 0, 0, 1, 3);
        wait_done(lat);
        chki("t3_gap_latency", lat, 9);
        chkp("t3_gap_product", product, 32'h00000012);
        release_out();

        // hold in DONE, then back-to-back
        kick();
        feed(15, 0, 0, 0, 0, 0);
        wait_done(lat);
        repeat (5) begin
            step();
            chkb("hold_out_valid", out_valid, 1'b1);
            chkp("hold_product", product, 32'h0000000F);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        t0 = cyc;
        chkb("b2b_pp_ready", pp_ready, 1'b1);
        feed(15, 0, 0, 0, 0, 0);
        wait_done(lat);
        chki("b2b_latency", lat, 5);
        chkp("b2b_product", product, 32'h0000000F);
        release_out();

        // reset after the 2nd handshake
        kick();
        pp_valid = 1'b1;
        pp_data  = enc(15);
        step();
        pp_data  = enc(0);
        step();
        rst_n = 1'b0;
        #1;
        chkb("midrst_pp_ready", pp_ready, 1'b0);
        chkb("midrst_out_valid", out_valid, 1'b0);
        chkb("midrst_busy", busy, 1'b0);
        chkp("midrst_product", product, '0);
        pp_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        kick();
        feed(-7, 0, 0, 0, 0, 0);
        wait_done(lat);
        chkp("t2_product", product, 32'hFFFFFFF9);
        release_out();

`ifdef PP_ACC_ABORT_EN
        kick();
        pp_valid = 1'b1;
        pp_data  = enc(15);
        step();
        pp_data  = enc(0);
        step();
        abort = 1'b1;
        step();
        abort    = 1'b0;
        pp_valid = 1'b0;
        chkb("abort_busy", busy, 1'b0);
        chkb("abort_pp_ready", pp_ready, 1'b0);
        pp_valid = 1'b1;
        repeat (6) begin
            step();
            chkb("abort_no_out_valid", out_valid, 1'b0);
        end
        pp_valid = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chkb("abort_start_idle", busy, 1'b0);
        kick();
        feed(-14, 2, 0, 0, 0, 0);
        wait_done(lat);
        chkp("abort_after_product", product, 32'h00000012);
        release_out();
`endif

        // randomized handshakes; the model checks every cycle
        for (int i = 0; i < 1500; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            pp_valid  = ($urandom_range(0, 3) != 0);
            pp_data   = enc(int'($urandom_range(0, 2 * PPMAX)) - PPMAX);
            out_ready = ($urandom_range(0, 2) == 0);
`ifdef PP_ACC_ABORT_EN
            abort     = ($urandom_range(0, 80) == 0);
`endif
            step();
        end
        start     = 1'b0;
        pp_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef PP_ACC_ABORT_EN
        abort     = 1'b0;
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
